word_entry_ctrl: RTL

//   Sequences one rotary_letter instance to enter a word of up to MAX_LEN letters.

---
 rtl/word_entry_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/word_entry_ctrl.sv
// Word entry sequencer: walks a cursor over a letter buffer, reloading and
// enabling one rotary_letter per slot, and commits letters on NEXT / re-edits on BACK.
module word_entry_ctrl #(
  parameter int MAX_LEN  = 8,
  parameter int LETTER_W = 5,
  parameter int CUR_W    = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         btn_next,
  input  logic                         btn_back,
  input  logic [LETTER_W-1:0]          letter_in,
  output logic                         rot_enable,
  output logic                         rot_reset,
  output logic [LETTER_W-1:0]          rot_reset_val,
  output logic [CUR_W-1:0]             cursor,
  output logic [MAX_LEN*LETTER_W-1:0]  word,
  output logic [CUR_W:0]               length,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   state_dbg
);

  // Handshake: start/btn_next/btn_back are single-cycle strobes sampled on the
  // rising clock edge; start is consumed only in IDLE, buttons only in EDIT.
  // done is a one-cycle strobe qualifying word and length.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EDIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [LETTER_W-1:0] END_CODE = LETTER_W'(26);
  localparam logic [CUR_W-1:0]    LAST_CUR = CUR_W'(MAX_LEN - 1);

  state_t                state_q, state_d;
  logic [CUR_W-1:0]      cursor_q, cursor_d;
  logic [CUR_W:0]        length_q, length_d;
  logic [LETTER_W-1:0]   slots_q [MAX_LEN];
  logic [LETTER_W-1:0]   slots_d [MAX_LEN];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cursor_q <= '0;
      length_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) slots_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      length_q <= length_d;
      for (int i = 0; i < MAX_LEN; i++) slots_q[i] <= slots_d[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    length_d = length_q;
    for (int i = 0; i < MAX_LEN; i++) slots_d[i] = slots_q[i];

    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < MAX_LEN; i++) slots_d[i] = '0;
          cursor_d = '0;
          length_d = '0;
          state_d  = LOAD;
        end
      end
      LOAD: state_d = EDIT;
      EDIT: begin
        // NEXT has priority; a coincident BACK is dropped.
        if (btn_next) begin
          if (letter_in >= END_CODE) begin
            length_d = {1'b0, cursor_q};
            state_d  = DONE;
          end else begin
            slots_d[cursor_q] = letter_in;
            if (cursor_q == LAST_CUR) begin
              length_d = (CUR_W+1)'(MAX_LEN);
              state_d  = DONE;
            end else begin
              cursor_d = cursor_q + 1'b1;
              state_d  = LOAD;
            end
          end
        end else if (btn_back && cursor_q != '0) begin
          cursor_d = cursor_q - 1'b1;
          state_d  = LOAD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rot_enable    = (state_q == EDIT);
  assign rot_reset     = (state_q == LOAD);
  assign rot_reset_val = (state_q == LOAD) ? slots_q[cursor_q] : '0;
  assign cursor        = cursor_q;
  assign length        = length_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign state_dbg     = state_q;

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_word
    assign word[g*LETTER_W +: LETTER_W] = slots_q[g];
  end

endmodule
